// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, HALT opcode, fetch FSM states and PC step.
// Consumers: fetch_stage (HALTED state used only when FETCH_HALT_EN is defined).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam logic [5:0] HALT    = 6'h3F;
    localparam word_t      PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input word_t w);
        return (w[31:26] == HALT);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache handshake and feeds IF/ID.
// Optional macro FETCH_HALT_EN: a handed-off HALT parks fetch in HALTED until redirect.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction_out,
    output logic [31:0] normal_pc_out,
    output logic [31:0] next_pc_out,
    output logic        update_out,
    output logic        flush_out
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    word_t        r_pc;
    word_t        r_hold;
    word_t        r_tgt;
    word_t        r_instr_last;
    word_t        r_npc_last;
    word_t        w_pc_plus4;
    word_t        w_pc_next;
    word_t        w_tgt_next;
    word_t        w_hold_next;
    logic         w_update;

    assign w_pc_plus4 = r_pc + PC_STEP;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                if (redirect) begin
                    w_next_state = ihit ? FETCH : DRAIN;
                end else if (ihit && stall) begin
                    w_next_state = HOLD;
`ifdef FETCH_HALT_EN
                end else if (ihit && is_halt(iload)) begin
                    w_next_state = HALTED;
`endif
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_next_state = FETCH;
                end else if (!stall) begin
`ifdef FETCH_HALT_EN
                    w_next_state = is_halt(r_hold) ? HALTED : FETCH;
`else
                    w_next_state = FETCH;
`endif
                end
            end
            DRAIN: begin
                if (ihit) begin
                    w_next_state = FETCH;
                end
            end
`ifdef FETCH_HALT_EN
            HALTED: begin
                if (redirect) begin
                    w_next_state = FETCH;
                end
            end
`endif
            default: w_next_state = FETCH;
        endcase
    end

    // Redirect always suppresses the IF/ID update; reset gates the handshake outputs.
    always_comb begin
        w_update        = 1'b0;
        iREN            = 1'b0;
        instruction_out = r_instr_last;
        case (r_state)
            FETCH: begin
                iREN     = nRST;
                w_update = nRST && ihit && !stall && !redirect;
                if (w_update) begin
                    instruction_out = iload;
                end
            end
            HOLD: begin
                w_update        = nRST && !stall && !redirect;
                instruction_out = r_hold;
            end
            DRAIN: begin
                iREN = nRST;
            end
            default: ;
        endcase
    end

    assign update_out    = w_update;
    assign flush_out     = redirect;
    assign iaddr         = r_pc;
    assign next_pc_out   = w_pc_plus4;
    assign normal_pc_out = w_update ? w_pc_plus4 : r_npc_last;

    always_comb begin
        w_pc_next   = r_pc;
        w_tgt_next  = r_tgt;
        w_hold_next = r_hold;
        case (r_state)
            FETCH: begin
                if (redirect && ihit) begin
                    w_pc_next = redirect_pc;
                end else if (redirect) begin
                    w_tgt_next = redirect_pc;
                end else if (ihit && stall) begin
                    w_hold_next = iload;
                end else if (ihit) begin
                    w_pc_next = w_pc_plus4;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_pc_next = redirect_pc;
                end else if (!stall) begin
                    w_pc_next = w_pc_plus4;
                end
            end
            DRAIN: begin
                // A redirect coinciding with the returning miss is the newest target.
                if (redirect) begin
                    w_tgt_next = redirect_pc;
                end
                if (ihit) begin
                    w_pc_next = redirect ? redirect_pc : r_tgt;
                end
            end
`ifdef FETCH_HALT_EN
            HALTED: begin
                if (redirect) begin
                    w_pc_next = redirect_pc;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pc   <= PC_INIT;
            r_hold <= '0;
            r_tgt  <= PC_INIT;
        end else begin
            r_pc   <= w_pc_next;
            r_hold <= w_hold_next;
            r_tgt  <= w_tgt_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_update) begin
            r_instr_last <= instruction_out;
            r_npc_last   <= w_pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall hold, miss redirect, wrap and HALT.
// Checks the FETCH_HALT_EN build when that macro is defined, the plain build otherwise.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction_out;
    logic [31:0] normal_pc_out;
    logic [31:0] next_pc_out;
    logic        update_out;
    logic        flush_out;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .iload          (iload),
        .iREN           (iREN),
        .iaddr          (iaddr),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instruction_out(instruction_out),
        .normal_pc_out  (normal_pc_out),
        .next_pc_out    (next_pc_out),
        .update_out     (update_out),
        .flush_out      (flush_out)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic h, input logic [31:0] ld, input logic st,
                         input logic rd, input logic [31:0] rpc);
        ihit        = h;
        iload       = ld;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge CLK);
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b1, 32'hAAAA_0000, 1'b0, 1'b0, 32'h0);
        check("rst_update", {31'b0, update_out}, 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        advance();
        nRST = 1'b1;

        // Sequential hits: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hAAAA_0000 + i, 1'b0, 1'b0, 32'h0);
            check("seq_iren", {31'b0, iREN}, 32'd1);
            check("seq_iaddr", iaddr, 32'(i * 4));
            check("seq_update", {31'b0, update_out}, 32'd1);
            check("seq_instr", instruction_out, 32'hAAAA_0000 + i);
            check("seq_npc", normal_pc_out, 32'(i * 4 + 4));
            advance();
        end

        // Hit under stall at pc=0x10, then three stalled HOLD cycles.
        drive(1'b1, 32'h2001_0005, 1'b1, 1'b0, 32'h0);
        check("stall_hit_update", {31'b0, update_out}, 32'd0);
        check("stall_hit_iaddr", iaddr, 32'h10);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            check("hold_iren", {31'b0, iREN}, 32'd0);
            check("hold_instr", instruction_out, 32'h2001_0005);
            check("hold_update", {31'b0, update_out}, 32'd0);
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("release_update", {31'b0, update_out}, 32'd1);
        check("release_instr", instruction_out, 32'h2001_0005);
        check("release_npc", normal_pc_out, 32'h14);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("after_hold_iaddr", iaddr, 32'h14);
        check("after_hold_iren", {31'b0, iREN}, 32'd1);
        advance();

        // Redirect with a hit: jump straight to 0x40.
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h40);
        check("rd_hit_update", {31'b0, update_out}, 32'd0);
        check("rd_hit_flush", {31'b0, flush_out}, 32'd1);
        advance();

        // Miss at 0x40, redirect to 0x100 goes to DRAIN.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        check("miss_rd_iaddr", iaddr, 32'h40);
        check("miss_rd_update", {31'b0, update_out}, 32'd0);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("drain_iaddr", iaddr, 32'h40);
        check("drain_iren", {31'b0, iREN}, 32'd1);
        advance();
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        check("drain_hit_update", {31'b0, update_out}, 32'd0);
        check("drain_hit_iaddr", iaddr, 32'h40);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("drain_target", iaddr, 32'h100);
        advance();

        // Two redirects during a miss: the later one wins.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        advance();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check("drain2_update", {31'b0, update_out}, 32'd0);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("last_rd_wins", iaddr, 32'h300);
        advance();

        // Redirect while in HOLD (stall still high) drops the held word.
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        advance();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        check("hold_rd_flush", {31'b0, flush_out}, 32'd1);
        check("hold_rd_update", {31'b0, update_out}, 32'd0);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("hold_rd_iaddr", iaddr, 32'h80);
        check("hold_rd_iren", {31'b0, iREN}, 32'd1);
        advance();

        // PC wrap at the top of the address space.
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        advance();
        drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        check("wrap_iaddr", iaddr, 32'hFFFF_FFFC);
        check("wrap_npc", normal_pc_out, 32'h0);
        check("wrap_update", {31'b0, update_out}, 32'd1);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap_next_iaddr", iaddr, 32'h0);
        check("wrap_next_pc", next_pc_out, 32'h4);
        advance();

        // HALT word handed off at pc=0.
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        check("halt_handoff", {31'b0, update_out}, 32'd1);
        advance();
`ifdef FETCH_HALT_EN
        drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        check("halted_iren", {31'b0, iREN}, 32'd0);
        check("halted_update", {31'b0, update_out}, 32'd0);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
        check("halted_rd_update", {31'b0, update_out}, 32'd0);
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("halt_resume_iaddr", iaddr, 32'h20);
        check("halt_resume_iren", {31'b0, iREN}, 32'd1);
        advance();
`else
        drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        check("nohalt_iaddr", iaddr, 32'h4);
        check("nohalt_update", {31'b0, update_out}, 32'd1);
        advance();
`endif

        // Mid-operation reset while a miss is draining.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
        advance();
        nRST = 1'b0;
        #1;
        check("midrst_iaddr", iaddr, 32'h0);
        check("midrst_update", {31'b0, update_out}, 32'd0);
        advance();
        nRST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("postrst_iaddr", iaddr, 32'h0);
        check("postrst_iren", {31'b0, iREN}, 32'd1);
        advance();
        drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
        check("postrst_update", {31'b0, update_out}, 32'd1);
        check("postrst_instr", instruction_out, 32'h3333_3333);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
